// File: rtl/sample_format_conv_if.sv
// sample_format_conv_if: valid/ready sample bus with per-beat mode for the format converter
interface sample_format_conv_if #(
  parameter int IN_W = 16,
  parameter int OUT_W = 16,
  parameter int CHANNELS = 2
);
  logic [1:0] mode;
  logic in_vld;
  logic in_rdy;
  logic [CHANNELS*IN_W-1:0] in_data;
  logic out_vld;
  logic out_rdy;
  logic [CHANNELS*OUT_W-1:0] out_data;
  logic [CHANNELS-1:0] out_clip;
  modport master (output mode, in_vld, in_data, out_rdy, input in_rdy, out_vld, out_data, out_clip);
  modport slave (input mode, in_vld, in_data, out_rdy, output in_rdy, out_vld, out_data, out_clip);
endinterface

// File: rtl/sample_format_conv.sv
// sample_format_conv: 2-stage PCM coding/width converter with rounding, saturation and clip counting
module sample_format_conv #(
  parameter int IN_W = 16,
  parameter int OUT_W = 16,
  parameter int CHANNELS = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  sample_format_conv_if.slave bus,
  output logic [CNT_W-1:0] clip_cnt
);
  localparam logic [CHANNELS*OUT_W-1:0] MSBS = {CHANNELS{{1'b1, {(OUT_W-1){1'b0}}}}};
  logic [CHANNELS*OUT_W-1:0] nar;
  logic [CHANNELS-1:0] clp;
  logic s2_adv, in_rdy, in_fire;
  logic s1_vld_q, s1_vld_d, s1_off_q, s1_off_d;
  logic [CHANNELS*OUT_W-1:0] s1_data_q, s1_data_d;
  logic [CHANNELS-1:0] s1_clip_q, s1_clip_d;
  logic out_vld_q, out_vld_d;
  logic [CHANNELS*OUT_W-1:0] out_data_q, out_data_d;
  logic [CHANNELS-1:0] out_clip_q, out_clip_d;
  logic [CNT_W-1:0] clip_cnt_q, clip_cnt_d;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [IN_W-1:0] s;
    assign s = $signed({bus.in_data[c*IN_W+IN_W-1] ^ bus.mode[0], bus.in_data[c*IN_W +: IN_W-1]});
    if (OUT_W >= IN_W) begin : g_wide
      assign nar[c*OUT_W +: OUT_W] = OUT_W'(s) <<< (OUT_W - IN_W);
      assign clp[c] = 1'b0;
    end else begin : g_narrow
      localparam int D = IN_W - OUT_W;
      logic signed [IN_W:0] r;
      // adding half an output LSB before the arithmetic shift rounds half toward +inf
      assign r = ((IN_W+1)'(s) + (IN_W+1)'(2**(D-1))) >>> D;
      assign clp[c] = r > (IN_W+1)'(2**(OUT_W-1) - 1);
      assign nar[c*OUT_W +: OUT_W] = clp[c] ? {1'b0, {(OUT_W-1){1'b1}}} : r[OUT_W-1:0];
    end
  end
  always_comb begin
    s2_adv = ~out_vld_q | bus.out_rdy;
    in_rdy = ~rst & (~s1_vld_q | s2_adv);
    in_fire = bus.in_vld & in_rdy;
    s1_vld_d = in_rdy ? in_fire : s1_vld_q;
    s1_data_d = in_fire ? nar : s1_data_q;
    s1_clip_d = in_fire ? clp : s1_clip_q;
    s1_off_d = in_fire ? ~(bus.mode[0] ^ bus.mode[1]) : s1_off_q;
    out_vld_d = s2_adv ? s1_vld_q : out_vld_q;
    out_data_d = (s2_adv & s1_vld_q) ? (s1_data_q ^ (s1_off_q ? MSBS : '0)) : out_data_q;
    out_clip_d = (s2_adv & s1_vld_q) ? s1_clip_q : out_clip_q;
    clip_cnt_d = clip_cnt_q + CNT_W'(in_fire & (|clp) & ~(&clip_cnt_q));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_off_q <= 1'b0;
      s1_data_q <= '0;
      s1_clip_q <= '0;
      out_vld_q <= 1'b0;
      out_data_q <= '0;
      out_clip_q <= '0;
      clip_cnt_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_off_q <= s1_off_d;
      s1_data_q <= s1_data_d;
      s1_clip_q <= s1_clip_d;
      out_vld_q <= out_vld_d;
      out_data_q <= out_data_d;
      out_clip_q <= out_clip_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end
  assign bus.in_rdy = in_rdy;
  assign bus.out_vld = out_vld_q;
  assign bus.out_data = out_data_q;
  assign bus.out_clip = out_clip_q;
  assign clip_cnt = clip_cnt_q;
endmodule
